spi_param_master: RTL and testbench

SPI_PARAM_MASTER -- requirements
Module: spi_param_master

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_edge_gen.sv | 53 +++++
 rtl/spi_param_master.sv | 183 ++++++++++++++++++
 tb/tb_spi_param_master.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI parameter master: FSM encoding and SPI mode bits.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  // mode = {CPOL, CPHA}
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK divider: while enabled, toggles sclk every CLK_DIV cycles starting with the
// first enabled cycle; lead/trail flag the cycle whose closing edge moves sclk away
// from / back to the idle level. While disabled sclk parks at cpol.
module spi_edge_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic cpol,
  output logic sclk,
  output logic lead,
  output logic trail
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic          tick;

  // Divider counter and sclk next-state
  always_comb begin
    tick   = en && (cnt_q == '0);
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = cpol;
    end else if (tick) begin
      cnt_d  = CW'(CLK_DIV - 1);
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q - 1'b1;
    end
  end

  // Divider registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk  = sclk_q;
  assign lead  = tick && (sclk_q == cpol);
  assign trail = tick && (sclk_q != cpol);

endmodule

// File: rtl/spi_param_master.sv
// Single-word SPI master with selectable mode, slave select and word width.
// Registered outputs; done/rx_data/busy line up in the cycle after HOLD ends.
module spi_param_master
  import spi_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_SS  = 3,
  parameter  int CLK_DIV = 4,
  localparam int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int TW = $clog2(2 * DATA_W * CLK_DIV);
  localparam int EW = $clog2(2 * DATA_W);

  spi_state_e        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [EW-1:0]     edge_idx_q, edge_idx_d;
  logic [1:0]        mode_q, mode_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;

  logic accept, valid_start, finishing, active;
  logic lead, trail, shift_en, sample_en, cpha;

  // The done cycle is already IDLE but still busy; holding off acceptance there
  // makes the earliest follow-on start the cycle after done.
  assign accept      = start && (state_q == ST_IDLE) && !busy_q;
  assign valid_start = accept && (32'(ss_sel) < NUM_SS);
  assign finishing   = (state_q == ST_HOLD) && (timer_q == '0);

  // Edge generator follows the mode being latched so sclk parks at the new CPOL
  // in the same cycle ss_n falls.
  spi_edge_gen #(.CLK_DIV(CLK_DIV)) u_edge (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_XFER),
    .cpol  (mode_d[CPOL_BIT]),
    .sclk  (sclk),
    .lead  (lead),
    .trail (trail)
  );

  // State and timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Next-state: each phase runs a down-counter to terminal count
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_start) begin
          state_d = ST_SETUP;
          timer_d = TW'(CLK_DIV - 1);
        end
      end
      ST_SETUP: begin
        if (timer_q == '0) begin
          state_d = ST_XFER;
          timer_d = TW'(2 * DATA_W * CLK_DIV - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_XFER: begin
        if (timer_q == '0) begin
          state_d = ST_HOLD;
          timer_d = TW'(CLK_DIV - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CPHA=1 presents the MSB before the first leading edge, so that edge must not
  // shift; CPHA=0 must not shift after the final trailing edge.
  assign cpha      = mode_q[CPHA_BIT];
  assign shift_en  = cpha ? (lead && (edge_idx_q != '0))
                          : (trail && (edge_idx_q != EW'(2 * DATA_W - 1)));
  assign sample_en = cpha ? trail : lead;
  assign active    = (state_d != ST_IDLE);

  // Output and datapath next-values
  always_comb begin
    mode_d     = mode_q;
    sel_d      = sel_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    edge_idx_d = edge_idx_q;
    rx_data_d  = rx_data_q;
    busy_d     = active || finishing;
    done_d     = finishing;
    err_d      = accept && !valid_start;
    if (valid_start) begin
      mode_d     = mode;
      sel_d      = ss_sel;
      tx_sh_d    = tx_data;
      rx_sh_d    = '0;
      edge_idx_d = '0;
    end else begin
      if (lead || trail) edge_idx_d = edge_idx_q + 1'b1;
      if (shift_en)      tx_sh_d    = {tx_sh_q[DATA_W-2:0], 1'b0};
      if (sample_en)     rx_sh_d    = {rx_sh_q[DATA_W-2:0], miso};
    end
    if (finishing) rx_data_d = rx_sh_q;
    for (int i = 0; i < NUM_SS; i++) begin
      ss_n_d[i] = !(active && (sel_d == SEL_W'(i)));
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE0;
      sel_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      edge_idx_q <= '0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ss_n_q     <= '1;
    end else begin
      mode_q     <= mode_d;
      sel_q      <= sel_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      edge_idx_q <= edge_idx_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ss_n_q     <= ss_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign mosi    = tx_sh_q[DATA_W-1];
  assign ss_n    = ss_n_q;

endmodule

// File: tb/tb_spi_param_master.sv
// Scoreboard bench: stimulus pushes expected results, negedge monitors pop on done/err.
module tb_spi_param_master;

  localparam int DW    = 8;
  localparam int NSS   = 3;
  localparam int DIV   = 4;
  localparam int DW_B  = 16;
  localparam int DIV_B = 2;
  localparam int LAT_A = (2 * DW + 2) * DIV + 1;
  localparam int LAT_B = (2 * DW_B + 2) * DIV_B + 1;

  typedef struct {
    logic [31:0]    rx;
    int             s;
    logic [NSS-1:0] ssv;
    logic           cpol;
    bit             chk_slv;
    logic [31:0]    slv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  logic           reset;
  logic           start;
  logic [1:0]     mode;
  logic [1:0]     ss_sel;
  logic [DW-1:0]  tx_data, rx_data;
  logic           busy, done, err, sclk, mosi, miso;
  logic [NSS-1:0] ss_n;

  logic            start_b;
  logic [1:0]      mode_b;
  logic [1:0]      ss_sel_b;
  logic [DW_B-1:0] tx_b, rx_b;
  logic            busy_b, done_b, err_b, sclk_b, mosi_b;
  logic [NSS-1:0]  ss_n_b;

  spi_param_master #(.DATA_W(DW), .NUM_SS(NSS), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ss_sel(ss_sel),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done), .err(err),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  spi_param_master #(.DATA_W(DW_B), .NUM_SS(NSS), .CLK_DIV(DIV_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode_b), .ss_sel(ss_sel_b),
    .tx_data(tx_b), .rx_data(rx_b), .busy(busy_b), .done(done_b), .err(err_b),
    .sclk(sclk_b), .mosi(mosi_b), .miso(mosi_b), .ss_n(ss_n_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   qerr[$];
  exp_t ea, eb;
  int   a_bad_ss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural SPI slave for instance A, reacting to sclk edges while selected
  logic [1:0]    slv_mode = 2'b00;
  logic [DW-1:0] slv_word = '0;
  logic [DW-1:0] slv_cap = '0;
  bit            slv_loop = 1'b0;
  logic          miso_r = 1'b0;
  logic          prev_sclk = 1'b0;
  bit            prev_sel = 1'b0;
  int            lead_n = 0;
  int            trail_n = 0;

  assign miso = slv_loop ? mosi : miso_r;

  always @(negedge clk) begin
    if (ss_n == '1) begin
      prev_sel = 1'b0;
      lead_n   = 0;
      trail_n  = 0;
      miso_r   = slv_word[DW-1];
    end else begin
      if (prev_sel && (sclk != prev_sclk)) begin
        if (sclk != slv_mode[1]) begin
          if (slv_mode[0]) miso_r = slv_word[DW-1-lead_n];
          else             slv_cap = {slv_cap[DW-2:0], mosi};
          lead_n++;
        end else begin
          if (slv_mode[0])           slv_cap = {slv_cap[DW-2:0], mosi};
          else if (trail_n < DW - 1) miso_r = slv_word[DW-2-trail_n];
          trail_n++;
        end
      end
      prev_sel = 1'b1;
    end
    prev_sclk = sclk;
  end

  // Monitor for instance A
  always @(negedge clk) begin
    if (busy && !done && qa.size() > 0) begin
      if (ss_n !== qa[0].ssv) a_bad_ss++;
    end
    if (done) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_rx_data", 32'(rx_data), ea.rx);
        chk("a_latency", cyc - ea.s + 1, LAT_A);
        chk("a_busy_at_done", 32'(busy), 32'd1);
        chk("a_ss_at_done", 32'(ss_n), 32'd7);
        chk("a_sclk_idle", 32'(sclk), 32'(ea.cpol));
        chk("a_ss_exclusive", a_bad_ss, 0);
        if (ea.chk_slv) chk("a_slave_capture", 32'(slv_cap), ea.slv);
        a_bad_ss = 0;
      end
    end
    if (err) begin
      if (qerr.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_err: got err=1 expected none (cycle %0d)", cyc);
      end else begin
        chk("a_err_cycle", cyc - qerr.pop_front() + 1, 1);
      end
    end
  end

  // Monitor for instance B (16-bit loopback)
  always @(negedge clk) begin
    if (done_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_rx_data", 32'(rx_b), eb.rx);
        chk("b_latency", cyc - eb.s + 1, LAT_B);
        chk("b_busy_at_done", 32'(busy_b), 32'd1);
        chk("b_ss_at_done", 32'(ss_n_b), 32'd7);
        chk("b_sclk_idle", 32'(sclk_b), 32'(eb.cpol));
      end
    end
  end

  function automatic logic [NSS-1:0] ss_pat(input int sel);
    logic [NSS-1:0] one;
    one = 1;
    return ~(one << sel);
  endfunction

  task automatic issue_a(input logic [1:0] md, input int sel, input logic [DW-1:0] tx,
                         input logic [DW-1:0] sw, input bit lp);
    exp_t e;
    @(negedge clk);
    slv_mode = md;
    slv_word = sw;
    slv_loop = lp;
    @(negedge clk);
    mode   = md;
    ss_sel = 2'(sel);
    tx_data = tx;
    start  = 1'b1;
    if (sel < NSS) begin
      e.rx      = 32'(lp ? tx : sw);
      e.s       = cyc + 1;
      e.ssv     = ss_pat(sel);
      e.cpol    = md[1];
      e.chk_slv = !lp;
      e.slv     = 32'(tx);
      qa.push_back(e);
    end else begin
      qerr.push_back(cyc + 1);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue_b(input logic [1:0] md, input int sel, input logic [DW_B-1:0] tx);
    exp_t e;
    @(negedge clk);
    mode_b   = md;
    ss_sel_b = 2'(sel);
    tx_b     = tx;
    start_b  = 1'b1;
    e.rx      = 32'(tx);
    e.s       = cyc + 1;
    e.ssv     = ss_pat(sel);
    e.cpol    = md[1];
    e.chk_slv = 1'b0;
    e.slv     = '0;
    qb.push_back(e);
    @(negedge clk);
    start_b = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || qerr.size() != 0 || busy || busy_b) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 32'(n < budget), 32'd1);
    qa.delete();
    qb.delete();
    qerr.delete();
  endtask

  initial begin
    int s0, d, n;
    logic [1:0]    md;
    int            sel;
    logic [DW-1:0] tx, sw;
    bit            lp;

    reset = 1'b1; start = 1'b0; mode = 2'b00; ss_sel = 2'd0; tx_data = '0;
    start_b = 1'b0; mode_b = 2'b00; ss_sel_b = 2'd0; tx_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(ss_n), 32'd7);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_b_ss_n", 32'(ss_n_b), 32'd7);
    chk("rst_b_rx_data", 32'(rx_b), 32'd0);
    reset = 1'b0;

    // Mode 0 loopback, slave 0
    issue_a(2'b00, 0, 8'hA5, 8'h00, 1'b1);
    drain(200);

    // Mode 3 against slave model, slave 2
    issue_a(2'b11, 2, 8'hC3, 8'h3C, 1'b0);
    drain(200);
    @(negedge clk);
    chk("mode3_sclk_idles_high", 32'(sclk), 32'd1);

    // Start held high; tx_data changed mid-transfer; back-to-back follow-on
    @(negedge clk);
    slv_loop = 1'b1;
    slv_mode = 2'b00;
    @(negedge clk);
    mode = 2'b00; ss_sel = 2'd1; tx_data = 8'h5A; start = 1'b1;
    ea.rx = 32'h5A; ea.s = cyc + 1; ea.ssv = ss_pat(1); ea.cpol = 1'b0;
    ea.chk_slv = 1'b0; ea.slv = '0;
    qa.push_back(ea);
    repeat (20) @(negedge clk);
    tx_data = 8'h96;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done_seen", 32'(done), 32'd1);
    d = cyc;
    ea.rx = 32'h96; ea.s = d + 2; ea.ssv = ss_pat(1); ea.cpol = 1'b0;
    ea.chk_slv = 1'b0; ea.slv = '0;
    qa.push_back(ea);
    @(negedge clk);
    chk("b2b_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", 32'(busy), 32'd1);
    drain(200);

    // Out-of-range slave select
    issue_a(2'b00, 3, 8'h11, 8'h00, 1'b1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_ss_n", 32'(ss_n), 32'd7);
    @(negedge clk);
    chk("err_busy_later", 32'(busy), 32'd0);
    chk("err_ss_n_later", 32'(ss_n), 32'd7);
    drain(20);

    // Reset in cycle 30 of a transfer: no done may follow
    @(negedge clk);
    slv_loop = 1'b1;
    @(negedge clk);
    mode = 2'b11; ss_sel = 2'd1; tx_data = 8'h77; start = 1'b1;
    s0 = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < s0 + 29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ss_n", 32'(ss_n), 32'd7);
    chk("abort_sclk", 32'(sclk), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    repeat (90) @(negedge clk);

    // Randomized transfers (slave index 3 exercises rejection)
    for (int k = 0; k < 8; k++) begin
      md  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 3);
      tx  = 8'($urandom);
      sw  = 8'($urandom);
      lp  = bit'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue_a(md, sel, tx, sw, lp);
      drain(200);
    end

    // 16-bit, divide-by-2 instance: mode 1 loopback then random words
    issue_b(2'b01, 0, 16'hBEEF);
    drain(200);
    for (int k = 0; k < 3; k++) begin
      issue_b(2'($urandom_range(0, 3)), $urandom_range(0, 2), 16'($urandom));
      drain(200);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
